// File: rtl/qc_ldpc_parity_encoder.sv
// Serial SRAA parity engine for the QC-LDPC encoder: one info bit per cycle.
// Optional synchronous codeword cancel: define ENC_ABORT_EN to add the i_abort port.
module qc_ldpc_parity_encoder #(
    parameter int CIRC   = 88,
    parameter int NB_ROW = 39,
    parameter int NB_PAR = 16
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef ENC_ABORT_EN
    input  logic                     i_abort,
`endif
    output logic [5:0]               o_g_sel,
    input  logic [NB_PAR*CIRC-1:0]   i_g_row,
    input  logic                     i_in_valid,
    input  logic                     i_in_bit,
    output logic                     o_in_ready,
    output logic                     o_par_valid,
    output logic [NB_PAR*CIRC-1:0]   o_par_data,
    input  logic                     i_par_ready
);

    localparam int W = NB_PAR * CIRC;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [5:0]     r_row_idx;
    logic [5:0]     w_row_nx;
    logic [6:0]     r_col_cnt;
    logic [6:0]     w_col_nx;
    logic [W-1:0]   r_shreg;
    logic [W-1:0]   w_shreg_nx;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   w_acc_nx;
    logic [W-1:0]   w_rot;
    logic           w_abort;

`ifdef ENC_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Every circulant segment rotates right by one column per accepted bit
    for (genvar s = 0; s < NB_PAR; s++) begin : g_rot
        assign w_rot[s*CIRC +: CIRC] =
            {r_shreg[s*CIRC], r_shreg[s*CIRC+1 +: CIRC-1]};
    end

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row_idx;
        w_col_nx   = r_col_cnt;
        w_shreg_nx = r_shreg;
        w_acc_nx   = r_acc;
        unique case (r_state)
            S_LOAD: begin
                w_shreg_nx = i_g_row;
                w_col_nx   = 7'd0;
                w_state_nx = S_ACCUM;
            end
            S_ACCUM: begin
                if (i_in_valid) begin
                    w_acc_nx   = r_acc ^ (i_in_bit ? r_shreg : '0);
                    w_shreg_nx = w_rot;
                    w_col_nx   = r_col_cnt + 7'd1;
                    if (r_col_cnt == 7'(CIRC - 1)) begin
                        w_col_nx = 7'd0;
                        if (r_row_idx == 6'(NB_ROW - 1)) begin
                            w_state_nx = S_OUT;
                        end else begin
                            w_row_nx   = r_row_idx + 6'd1;
                            w_state_nx = S_LOAD;
                        end
                    end
                end
            end
            S_OUT: begin
                if (i_par_ready) begin
                    w_acc_nx   = '0;
                    w_row_nx   = 6'd0;
                    w_state_nx = S_LOAD;
                end
            end
            default: begin
                w_state_nx = S_LOAD;
            end
        endcase
        if (w_abort) begin
            w_acc_nx   = '0;
            w_row_nx   = 6'd0;
            w_col_nx   = 7'd0;
            w_state_nx = S_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_row_idx <= 6'd0;
            r_col_cnt <= 7'd0;
            r_shreg   <= '0;
            r_acc     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_row_idx <= w_row_nx;
            r_col_cnt <= w_col_nx;
            r_shreg   <= w_shreg_nx;
            r_acc     <= w_acc_nx;
        end
    end

    assign o_g_sel     = r_row_idx;
    assign o_in_ready  = (r_state == S_ACCUM);
    assign o_par_valid = (r_state == S_OUT);
    assign o_par_data  = r_acc;

endmodule
